// File: rtl/mem_pkg.sv
// Shared types and constants for the simple-dual-port memory bank and its
// response buffer.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RSP_DEPTH = 2;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Two-entry in-order read-response buffer. Entry 0 is always the head, so the
// response outputs come straight from flops and stay put while stalled.
module mem_rsp_fifo
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        cnt_next_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q [RSP_DEPTH];
  logic [DATA_W-1:0] data_d [RSP_DEPTH];
  logic              push_s, pop_s;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    pop_s  = pop_i && (cnt_q != 2'd0);
    push_s = push_i && ((cnt_q != 2'(RSP_DEPTH)) || pop_s);
    if (pop_s) begin
      data_d[0] = data_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    // After a pop the tail slot index equals the remaining count.
    if (push_s) begin
      data_d[cnt_d[0]] = push_data_i;
      cnt_d            = cnt_d + 2'd1;
    end
    vld_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      vld_q <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) data_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o      = vld_q;
  assign data_o     = data_q[0];
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/mem_sdp_bank.sv
// Simple-dual-port RAM bank with byte-enable writes, write-first collision
// bypass, a stallable read-response channel and a sequential clear engine.
module mem_sdp_bank
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 1 << ADDR_W,
  parameter     MEM_FILE  = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_vld_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic [strb_w(DATA_W)-1:0] wr_strb_i,
  output logic                      wr_rdy_o,
  input  logic                      rd_vld_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic                      rd_rdy_o,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      rd_data_vld_o,
  input  logic                      rd_data_rdy_i,
  input  logic                      clr_i,
  output logic                      busy_o,
  output logic                      clr_done_o
);

  localparam int              STRB_W   = strb_w(DATA_W);
  localparam int              IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_d,
                                                   input logic [DATA_W-1:0] new_d,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) res[8*k +: 8] = new_d[8*k +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              wr_rdy_q, wr_rdy_d;
  logic              rd_rdy_q, rd_rdy_d;
  logic              busy_q, busy_d;
  logic              clr_done_q, clr_done_d;

  logic              wr_acc_s, rd_acc_s;
  logic              wr_in_rng_s, rd_in_rng_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
  logic [DATA_W-1:0] wr_merged_s, rsp_data_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              rsp_vld_s;
  logic [1:0]        rsp_cnt_next_s;

  assign wr_acc_s    = wr_vld_i && wr_rdy_q;
  assign rd_acc_s    = rd_vld_i && rd_rdy_q;
  assign wr_in_rng_s = ({1'b0, wr_addr_i} < DEPTH_L);
  assign rd_in_rng_s = ({1'b0, rd_addr_i} < DEPTH_L);
  assign wr_idx_s    = wr_addr_i[IDX_W-1:0];
  assign rd_idx_s    = rd_addr_i[IDX_W-1:0];
  assign wr_merged_s = byte_merge(mem_q[wr_idx_s], wr_data_i, wr_strb_i);

  always_comb begin
    rsp_data_s = '0;
    if (!rd_in_rng_s) begin
      rsp_data_s = '0;
    end else if (wr_acc_s && wr_in_rng_s && (wr_addr_i == rd_addr_i)) begin
      rsp_data_s = wr_merged_s;
    end else begin
      rsp_data_s = mem_q[rd_idx_s];
    end
  end

  // The clear engine owns the write port for the whole sweep.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_idx_s;
    mem_wdata_s = wr_merged_s;
    if (state_q == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = '0;
    end else begin
      mem_we_s = wr_acc_s && wr_in_rng_s;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[mem_waddr_s] <= mem_wdata_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are computed from next-state so they register in step with it.
    wr_rdy_d   = (state_d == IDLE);
    rd_rdy_d   = (state_d == IDLE) && (rsp_cnt_next_s < 2'(RSP_DEPTH));
    busy_d     = (state_d == CLEAR);
    clr_done_d = (state_d == CLEAR) && (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_rdy_q   <= 1'b1;
      rd_rdy_q   <= 1'b1;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_rdy_q   <= wr_rdy_d;
      rd_rdy_q   <= rd_rdy_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  mem_rsp_fifo #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_acc_s),
    .push_data_i (rsp_data_s),
    .pop_i       (rd_data_rdy_i),
    .vld_o       (rsp_vld_s),
    .data_o      (rd_data_o),
    .cnt_next_o  (rsp_cnt_next_s)
  );

  assign rd_data_vld_o = rsp_vld_s;
  assign wr_rdy_o      = wr_rdy_q;
  assign rd_rdy_o      = rd_rdy_q;
  assign busy_o        = busy_q;
  assign clr_done_o    = clr_done_q;

endmodule

// File: tb/tb_mem_sdp_bank.sv
// Self-checking bench for mem_sdp_bank: directed scenarios plus randomized
// traffic checked against an array/queue reference model.
module tb_mem_sdp_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_vld_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic [3:0]    wr_strb_i = '0;
  logic          wr_rdy_o;
  logic          rd_vld_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_rdy_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_data_vld_o;
  logic          rd_data_rdy_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          busy_o;
  logic          clr_done_o;

  always #5 clk = ~clk;

  mem_sdp_bank #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_vld_i(wr_vld_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_strb_i(wr_strb_i), .wr_rdy_o(wr_rdy_o),
    .rd_vld_i(rd_vld_i), .rd_addr_i(rd_addr_i), .rd_rdy_o(rd_rdy_o),
    .rd_data_o(rd_data_o), .rd_data_vld_o(rd_data_vld_o), .rd_data_rdy_i(rd_data_rdy_i),
    .clr_i(clr_i), .busy_o(busy_o), .clr_done_o(clr_done_o)
  );

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic          obs_wr_rdy, obs_rd_rdy, obs_vld, obs_busy, obs_done, popped;
  logic [DW-1:0] obs_data, exp_pop;
  int            exp_out;

  // One clock of stimulus: records what the DUT showed this cycle and advances the model.
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [3:0] ws, input logic rv, input logic [AW-1:0] ra,
                      input logic rr, input logic clr);
    wr_vld_i = wv; wr_addr_i = wa; wr_data_i = wd; wr_strb_i = ws;
    rd_vld_i = rv; rd_addr_i = ra; rd_data_rdy_i = rr; clr_i = clr;
    obs_wr_rdy = wr_rdy_o; obs_rd_rdy = rd_rdy_o; obs_vld = rd_data_vld_o;
    obs_data = rd_data_o; obs_busy = busy_o; obs_done = clr_done_o;
    exp_out = exp_q.size();
    popped = obs_vld && rr;
    exp_pop = 'x;
    if (popped && exp_q.size() > 0) exp_pop = exp_q.pop_front();
    if (wv && obs_wr_rdy && int'(wa) < DEPTH) begin
      for (int k = 0; k < 4; k++) if (ws[k]) model_mem[wa][8*k +: 8] = wd[8*k +: 8];
    end
    if (rv && obs_rd_rdy) exp_q.push_back((int'(ra) < DEPTH) ? model_mem[ra] : 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, rr, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (wr_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy got %b want 1", wr_rdy_o); end
    n_tests++; if (rd_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rd_rdy got %b want 1", rd_rdy_o); end
    n_tests++; if (rd_data_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", rd_data_vld_o); end
    n_tests++; if (rd_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", rd_data_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_tests++; if (clr_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", clr_done_o); end
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    step(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 1'b1, 1'b0);
    n_tests++; if (obs_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_accept got %b want 1", obs_rd_rdy); end
    n_tests++; if (rd_data_vld_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency_vld got %b want 1", rd_data_vld_o); end
    n_tests++; if (rd_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data got %h want deadbeef", rd_data_o); end
    idle(1'b1);
    n_tests++; if (rd_data_vld_o !== 1'b0) begin n_fail++; $display("FAIL basic_consumed_vld got %b want 0", rd_data_vld_o); end
  endtask

  task automatic test_strb();
    step(1'b1, 5'd3, 32'h11223344, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd3, 32'hAABBCCDD, 4'h5, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 5'd3, 1'b1, 1'b0);
    idle(1'b1);
    n_tests++; if (!popped || obs_data !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb_merge got %h (vld %b) want 11bb33dd", obs_data, popped); end
  endtask

  task automatic test_collision();
    step(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd7, 32'h0000FFFF, 4'h3, 1'b1, 5'd7, 1'b1, 1'b0);
    step(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b1, 5'd7, 1'b1, 1'b0);
    n_tests++; if (!popped || obs_data !== 32'h1234FFFF) begin n_fail++; $display("FAIL collision_same got %h want 1234ffff", obs_data); end
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 1'b1, 1'b0);
    n_tests++; if (!popped || obs_data !== 32'h1234FFFF) begin n_fail++; $display("FAIL collision_other_addr got %h want 1234ffff", obs_data); end
    idle(1'b1);
    n_tests++; if (!popped || obs_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL later_read got %h want cafef00d", obs_data); end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 5'd4, 32'h44444444, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd20, 32'hBAD0BAD0, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd20, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4, 1'b1, 1'b0);
    n_tests++; if (!popped || obs_data !== 32'h0) begin n_fail++; $display("FAIL oor_read got %h want 0", obs_data); end
    idle(1'b1);
    n_tests++; if (!popped || obs_data !== 32'h44444444) begin n_fail++; $display("FAIL oor_alias got %h want 44444444", obs_data); end
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    int got = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 32'hA0 + 32'(i), 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(nxt), 1'b0, 1'b0);
      n_tests++; if (obs_rd_rdy !== (exp_out < 2)) begin n_fail++; $display("FAIL bp_rd_rdy got %b outstanding %0d", obs_rd_rdy, exp_out); end
      if (obs_rd_rdy) nxt++;
    end
    n_tests++; if (nxt !== 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", nxt); end
    n_tests++; if (rd_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_low got %b want 0", rd_rdy_o); end
    for (int c = 0; c < 20 && got < 4; c++) begin
      step(1'b0, 5'd0, 32'h0, 4'h0, (nxt < 4), 5'(nxt), 1'b1, 1'b0);
      n_tests++; if (obs_rd_rdy !== (exp_out < 2)) begin n_fail++; $display("FAIL bp_rd_rdy_rel got %b outstanding %0d", obs_rd_rdy, exp_out); end
      if (obs_rd_rdy && nxt < 4) nxt++;
      if (popped) begin
        n_tests++; if (obs_data !== 32'hA0 + 32'(got)) begin n_fail++; $display("FAIL bp_order got %h want %h", obs_data, 32'hA0 + 32'(got)); end
        got++;
      end
    end
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL bp_drain_timeout got %0d responses want 4", got); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i), $urandom, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    for (int c = 1; c <= DEPTH; c++) begin
      step(1'b1, 5'(c - 1), $urandom, 4'hF, 1'b1, 5'd0, 1'b1, 1'b1);
      n_tests++; if (obs_busy !== 1'b1 || obs_wr_rdy !== 1'b0 || obs_rd_rdy !== 1'b0) begin
        n_fail++; $display("FAIL clear_busy cyc %0d busy %b wr_rdy %b rd_rdy %b want 1 0 0", c, obs_busy, obs_wr_rdy, obs_rd_rdy); end
      n_tests++; if (obs_done !== (c == DEPTH)) begin n_fail++; $display("FAIL clear_done cyc %0d got %b", c, obs_done); end
    end
    idle(1'b1);
    n_tests++; if (obs_busy !== 1'b0 || obs_wr_rdy !== 1'b1 || obs_rd_rdy !== 1'b1 || obs_done !== 1'b0) begin
      n_fail++; $display("FAIL clear_end busy %b wr_rdy %b rd_rdy %b done %b want 0 1 1 0", obs_busy, obs_wr_rdy, obs_rd_rdy, obs_done); end
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b0, 5'd0, 32'h0, 4'h0, (i < DEPTH), 5'(i), 1'b1, 1'b0);
      if (popped) begin
        n_tests++; if (obs_data !== 32'h0) begin n_fail++; $display("FAIL clear_read got %h want 0", obs_data); end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i), $urandom, 4'hF, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b1, 1'b1);
    repeat (8) idle(1'b1);
    rst = 1'b1;
    #1;
    n_tests++; if (wr_rdy_o !== 1'b1 || rd_rdy_o !== 1'b1 || busy_o !== 1'b0 || rd_data_vld_o !== 1'b0 || clr_done_o !== 1'b0 || rd_data_o !== 32'h0) begin
      n_fail++; $display("FAIL abort_outputs wr %b rd %b busy %b vld %b done %b data %h", wr_rdy_o, rd_rdy_o, busy_o, rd_data_vld_o, clr_done_o, rd_data_o); end
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b0, 5'd0, 32'h0, 4'h0, (i < DEPTH), 5'(i), 1'b1, 1'b0);
      if (popped) begin
        n_tests++; if (obs_data !== exp_pop) begin n_fail++; $display("FAIL abort_read got %h want %h", obs_data, exp_pop); end
      end
    end
  endtask

  task automatic test_random();
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] wa, ra;
    logic          rr;
    for (int c = 0; c < 400; c++) begin
      wa = 5'($urandom_range(0, 19));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 19));
      rr = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ra, rr, 1'b0);
      n_tests++; if (obs_vld !== (exp_out > 0)) begin n_fail++; $display("FAIL rnd_vld cyc %0d got %b outstanding %0d", c, obs_vld, exp_out); end
      n_tests++; if (obs_rd_rdy !== (exp_out < 2) || obs_wr_rdy !== 1'b1) begin
        n_fail++; $display("FAIL rnd_rdy cyc %0d rd %b wr %b outstanding %0d", c, obs_rd_rdy, obs_wr_rdy, exp_out); end
      if (popped) begin
        n_tests++; if (obs_data !== exp_pop) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", c, obs_data, exp_pop); end
      end
      if (prev_stall && obs_vld) begin
        n_tests++; if (obs_data !== prev_data) begin n_fail++; $display("FAIL rnd_hold cyc %0d got %h want %h", c, obs_data, prev_data); end
      end
      prev_stall = obs_vld && !rr;
      prev_data  = obs_data;
    end
    for (int c = 0; c < 4; c++) begin
      idle(1'b1);
      if (popped) begin
        n_tests++; if (obs_data !== exp_pop) begin n_fail++; $display("FAIL rnd_drain got %h want %h", obs_data, exp_pop); end
      end
    end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_strb();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
